// File: rtl/cm_config_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// cm_config_dispatcher_pkg
// Shared configuration-manager constants for the configuration dispatcher:
//   - default parameter values for the C_* write channel and colour FIFO
//   - register address map (0..5)
//   - field widths of the UART and VGA selects and their reset codes
//   - packed shadow/live register structs and the two FSM state enums
//   - small address-decode helpers
// ---------------------------------------------------------------------------
package cm_config_dispatcher_pkg;

    localparam int CM_ADDR_WIDTH       = 4;
    localparam int CM_DATA_WIDTH       = 14;
    localparam int CM_COLOR_FIFO_DEPTH = 4;

    localparam int unsigned ADDR_BAUD   = 0;
    localparam int unsigned ADDR_PARITY = 1;
    localparam int unsigned ADDR_STOP   = 2;
    localparam int unsigned ADDR_RES    = 3;
    localparam int unsigned ADDR_QUAD   = 4;
    localparam int unsigned ADDR_COLOR  = 5;

    localparam int BAUD_W = 3;
    localparam int PAR_W  = 2;
    localparam int STOP_W = 1;
    localparam int RES_W  = 2;
    localparam int QUAD_W = 2;

    // Baud code 2 selects 9600 baud.
    localparam logic [BAUD_W-1:0] BAUD_DEFAULT   = 3'd2;
    localparam logic [PAR_W-1:0]  PARITY_DEFAULT = 2'd0;
    localparam logic [STOP_W-1:0] STOP_DEFAULT   = 1'b0;
    localparam logic [RES_W-1:0]  RES_DEFAULT    = 2'd0;
    localparam logic [QUAD_W-1:0] QUAD_DEFAULT   = 2'd0;

    typedef struct packed {
        logic [BAUD_W-1:0] baud;
        logic [PAR_W-1:0]  parity;
        logic [STOP_W-1:0] stop;
    } uart_cfg_t;

    typedef struct packed {
        logic [RES_W-1:0]  res;
        logic [QUAD_W-1:0] quad;
    } vga_cfg_t;

    localparam uart_cfg_t UART_CFG_DEFAULT = '{baud: BAUD_DEFAULT,
                                               parity: PARITY_DEFAULT,
                                               stop: STOP_DEFAULT};
    localparam vga_cfg_t  VGA_CFG_DEFAULT  = '{res: RES_DEFAULT,
                                               quad: QUAD_DEFAULT};

    typedef enum logic {U_IDLE, U_PEND} uart_state_t;
    typedef enum logic {V_IDLE, V_PEND} vga_state_t;

    function automatic logic is_uart_addr(input logic [31:0] addr);
        return (addr <= ADDR_STOP);
    endfunction

    function automatic logic is_vga_addr(input logic [31:0] addr);
        return (addr == ADDR_RES) || (addr == ADDR_QUAD);
    endfunction

endpackage

// File: rtl/cm_config_dispatcher_if.sv
// ---------------------------------------------------------------------------
// cm_config_dispatcher_if
// Bundles the configuration write channel and the colour output channel.
//   C_Addr/C_Data/C_Valid : write from the configuration manager
//   C_Rdy                 : dispatcher can take a write
//   Color_Data/Valid/Ack  : FWFT colour stream towards the VGA colour port
//   Cfg_Drop              : one-cycle pulse when a write is discarded
// Modports: master = configuration manager / colour consumer side,
//           slave  = dispatcher side.
// ---------------------------------------------------------------------------
interface cm_config_dispatcher_if
    import cm_config_dispatcher_pkg::*;
#(
    parameter int C_ADDR_WIDTH = CM_ADDR_WIDTH,
    parameter int C_DATA_WIDTH = CM_DATA_WIDTH
);

    logic [C_ADDR_WIDTH-1:0] C_Addr;
    logic [C_DATA_WIDTH-1:0] C_Data;
    logic                    C_Valid;
    logic                    C_Rdy;
    logic [C_DATA_WIDTH-1:0] Color_Data;
    logic                    Color_Valid;
    logic                    Color_Ack;
    logic                    Cfg_Drop;

    modport master (
        output C_Addr, C_Data, C_Valid, Color_Ack,
        input  C_Rdy, Color_Data, Color_Valid, Cfg_Drop
    );

    modport slave (
        input  C_Addr, C_Data, C_Valid, Color_Ack,
        output C_Rdy, Color_Data, Color_Valid, Cfg_Drop
    );

endinterface

// File: rtl/cm_color_fifo.sv
// ---------------------------------------------------------------------------
// cm_color_fifo
// Synchronous first-word-fall-through FIFO for colour words.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   i_push     : write i_data (accepted if not full, or if a pop frees a slot)
//   i_pop      : remove the head (ignored when empty)
//   o_head     : current head word
//   o_count    : number of stored words (0..DEPTH)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
// DEPTH must be a power of two so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module cm_color_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cm_config_dispatcher.sv
// ---------------------------------------------------------------------------
// cm_config_dispatcher
// Consumes configuration writes and applies them at safe points.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : C_Addr/C_Data/C_Valid in, C_Rdy out,
//                     Color_Data/Color_Valid out, Color_Ack in, Cfg_Drop out
//   Uart_Busy       : UART mid-frame; UART selects are held while high
//   Frame_End       : last-pixel pulse; VGA selects change only here
//   Baud_Sel, Parity_Sel, Stop_Sel, Uart_Cfg_Update : applied UART config
//   Res_Sel, Quad_Sel, Vga_Cfg_Update               : applied VGA config
// Address map: 0 baud, 1 parity, 2 stop, 3 resolution, 4 quadrant,
// 5 colour (FIFO push). Other addresses are dropped with Cfg_Drop.
// C_DATA_WIDTH must match the width of the connected interface.
// ---------------------------------------------------------------------------
module cm_config_dispatcher
    import cm_config_dispatcher_pkg::*;
#(
    parameter int C_ADDR_WIDTH     = CM_ADDR_WIDTH,
    parameter int C_DATA_WIDTH     = CM_DATA_WIDTH,
    parameter int COLOR_FIFO_DEPTH = CM_COLOR_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cm_config_dispatcher_if.slave bus,
    input  logic                 Uart_Busy,
    input  logic                 Frame_End,
    output logic [BAUD_W-1:0]    Baud_Sel,
    output logic [PAR_W-1:0]     Parity_Sel,
    output logic [STOP_W-1:0]    Stop_Sel,
    output logic                 Uart_Cfg_Update,
    output logic [RES_W-1:0]     Res_Sel,
    output logic [QUAD_W-1:0]    Quad_Sel,
    output logic                 Vga_Cfg_Update
);

    localparam int CNT_W = $clog2(COLOR_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(COLOR_FIFO_DEPTH - 1);

    uart_state_t r_ustate, w_ustate_nxt;
    vga_state_t  r_vstate, w_vstate_nxt;
    uart_cfg_t   r_ushadow, w_ushadow_nxt, r_uart_sel;
    vga_cfg_t    r_vshadow, w_vshadow_nxt, r_vga_sel;
    logic        r_uart_upd, r_vga_upd;
    logic        r_rdy, r_drop;

    logic [31:0]             w_addr;
    logic                    w_uart_wr, w_vga_wr, w_col_wr, w_bad_wr;
    logic                    w_uapply, w_vapply;
    logic                    w_push, w_pop, w_col_drop;
    logic                    w_full, w_empty;
    logic [CNT_W-1:0]        w_count, w_count_nxt;
    logic [C_DATA_WIDTH-1:0] w_head;

    assign w_addr    = 32'(bus.C_Addr[C_ADDR_WIDTH-1:0]);
    assign w_uart_wr = bus.C_Valid && is_uart_addr(w_addr);
    assign w_vga_wr  = bus.C_Valid && is_vga_addr(w_addr);
    assign w_col_wr  = bus.C_Valid && (w_addr == ADDR_COLOR);
    assign w_bad_wr  = bus.C_Valid && (w_addr > ADDR_COLOR);

    assign w_pop      = !w_empty && bus.Color_Ack;
    assign w_push     = w_col_wr && (!w_full || w_pop);
    assign w_col_drop = w_col_wr && w_full && !w_pop;

    assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    cm_color_fifo #(
        .WIDTH (C_DATA_WIDTH),
        .DEPTH (COLOR_FIFO_DEPTH)
    ) u_color_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.C_Data),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Only the low field bits of C_Data land in the shadows.
    always_comb begin
        w_ushadow_nxt = r_ushadow;
        w_vshadow_nxt = r_vshadow;
        if (bus.C_Valid) begin
            case (w_addr)
                ADDR_BAUD:   w_ushadow_nxt.baud   = bus.C_Data[BAUD_W-1:0];
                ADDR_PARITY: w_ushadow_nxt.parity = bus.C_Data[PAR_W-1:0];
                ADDR_STOP:   w_ushadow_nxt.stop   = bus.C_Data[STOP_W-1:0];
                ADDR_RES:    w_vshadow_nxt.res    = bus.C_Data[RES_W-1:0];
                ADDR_QUAD:   w_vshadow_nxt.quad   = bus.C_Data[QUAD_W-1:0];
                default:     ;
            endcase
        end
    end

    // A write landing while already pending holds the apply off for one
    // cycle, so the newest field value is in the shadow when it is copied
    // and the domain still sees a single update pulse.
    always_comb begin
        w_ustate_nxt = r_ustate;
        w_uapply     = 1'b0;
        case (r_ustate)
            U_IDLE: begin
                if (w_uart_wr) begin
                    w_ustate_nxt = U_PEND;
                end
            end
            U_PEND: begin
                if (!w_uart_wr && !Uart_Busy) begin
                    w_ustate_nxt = U_IDLE;
                    w_uapply     = 1'b1;
                end
            end
            default: w_ustate_nxt = U_IDLE;
        endcase
    end

    always_comb begin
        w_vstate_nxt = r_vstate;
        w_vapply     = 1'b0;
        case (r_vstate)
            V_IDLE: begin
                if (w_vga_wr) begin
                    w_vstate_nxt = V_PEND;
                end
            end
            V_PEND: begin
                if (!w_vga_wr && Frame_End) begin
                    w_vstate_nxt = V_IDLE;
                    w_vapply     = 1'b1;
                end
            end
            default: w_vstate_nxt = V_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ustate   <= U_IDLE;
            r_ushadow  <= UART_CFG_DEFAULT;
            r_uart_sel <= UART_CFG_DEFAULT;
            r_uart_upd <= 1'b0;
        end else begin
            r_ustate   <= w_ustate_nxt;
            r_ushadow  <= w_ushadow_nxt;
            r_uart_upd <= w_uapply;
            if (w_uapply) begin
                r_uart_sel <= r_ushadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vstate  <= V_IDLE;
            r_vshadow <= VGA_CFG_DEFAULT;
            r_vga_sel <= VGA_CFG_DEFAULT;
            r_vga_upd <= 1'b0;
        end else begin
            r_vstate  <= w_vstate_nxt;
            r_vshadow <= w_vshadow_nxt;
            r_vga_upd <= w_vapply;
            if (w_vapply) begin
                r_vga_sel <= r_vshadow;
            end
        end
    end

    // Ready keeps one FIFO slot in reserve for a write already in flight
    // when C_Rdy falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy  <= 1'b1;
            r_drop <= 1'b0;
        end else begin
            r_rdy  <= !((w_ustate_nxt == U_PEND) || (w_vstate_nxt == V_PEND) ||
                        (w_count_nxt >= RDY_LIMIT));
            r_drop <= w_bad_wr || w_col_drop;
        end
    end

    assign bus.C_Rdy       = r_rdy;
    assign bus.Cfg_Drop    = r_drop;
    assign bus.Color_Data  = w_head;
    assign bus.Color_Valid = !w_empty;

    assign Baud_Sel        = r_uart_sel.baud;
    assign Parity_Sel      = r_uart_sel.parity;
    assign Stop_Sel        = r_uart_sel.stop;
    assign Uart_Cfg_Update = r_uart_upd;
    assign Res_Sel         = r_vga_sel.res;
    assign Quad_Sel        = r_vga_sel.quad;
    assign Vga_Cfg_Update  = r_vga_upd;

endmodule

// File: tb/tb_cm_config_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_cm_config_dispatcher
// Self-checking bench: directed vector table for the UART/VGA apply rules,
// hand-written FIFO and reset sequences, then randomized traffic compared
// against a behavioural model (arrays + queue).
// ---------------------------------------------------------------------------
module tb_cm_config_dispatcher;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Uart_Busy = 1'b0;
    logic       Frame_End = 1'b0;
    logic [2:0] Baud_Sel;
    logic [1:0] Parity_Sel;
    logic       Stop_Sel;
    logic       Uart_Cfg_Update;
    logic [1:0] Res_Sel;
    logic [1:0] Quad_Sel;
    logic       Vga_Cfg_Update;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int v, a, d, busy, fe, ack;
        int rdy, baud, par, stop, res, quad, uu, vu, drop;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: applied and shadow fields by address,
    // pending flag per domain, colour queue.
    int  mApplied[5];
    int  mShadow[5];
    int  mMask[5] = '{7, 3, 1, 3, 3};
    bit  mUPend, mVPend;
    int  mQ[$];

    cm_config_dispatcher_if #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(14)) bus();

    cm_config_dispatcher #(
        .C_ADDR_WIDTH     (4),
        .C_DATA_WIDTH     (14),
        .COLOR_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus.slave),
        .Uart_Busy       (Uart_Busy),
        .Frame_End       (Frame_End),
        .Baud_Sel        (Baud_Sel),
        .Parity_Sel      (Parity_Sel),
        .Stop_Sel        (Stop_Sel),
        .Uart_Cfg_Update (Uart_Cfg_Update),
        .Res_Sel         (Res_Sel),
        .Quad_Sel        (Quad_Sel),
        .Vga_Cfg_Update  (Vga_Cfg_Update)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic drive(input int v, input int a, input int d,
                         input int busy, input int fe, input int ack);
        bus.C_Valid   = 1'(v);
        bus.C_Addr    = 4'(a);
        bus.C_Data    = 14'(d);
        Uart_Busy     = 1'(busy);
        Frame_End     = 1'(fe);
        bus.Color_Ack = 1'(ack);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t t);
        drive(t.v, t.a, t.d, t.busy, t.fe, t.ack);
        tick();
    endtask

    task automatic checkVector(input vec_t t, input int idx);
        checkOutput($sformatf("vec%0d.rdy", idx),  bus.C_Rdy, t.rdy);
        checkOutput($sformatf("vec%0d.baud", idx), Baud_Sel, t.baud);
        checkOutput($sformatf("vec%0d.par", idx),  Parity_Sel, t.par);
        checkOutput($sformatf("vec%0d.stop", idx), Stop_Sel, t.stop);
        checkOutput($sformatf("vec%0d.res", idx),  Res_Sel, t.res);
        checkOutput($sformatf("vec%0d.quad", idx), Quad_Sel, t.quad);
        checkOutput($sformatf("vec%0d.uupd", idx), Uart_Cfg_Update, t.uu);
        checkOutput($sformatf("vec%0d.vupd", idx), Vga_Cfg_Update, t.vu);
        checkOutput($sformatf("vec%0d.drop", idx), bus.Cfg_Drop, t.drop);
    endtask

    task automatic doReset();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        mApplied = '{2, 0, 0, 0, 0};
        mShadow  = '{2, 0, 0, 0, 0};
        mUPend = 1'b0;
        mVPend = 1'b0;
        mQ.delete();
    endtask

    // One cycle of the reference model: returns expected pulses and
    // leaves the model holding the state visible after the clock edge.
    task automatic modelStep(input int v, input int a, input int d,
                             input int busy, input int fe, input int ack,
                             output int eUu, output int eVu, output int eDrop);
        bit uWr, vWr, uApply, vApply;
        uWr    = (v != 0) && (a <= 2);
        vWr    = (v != 0) && (a == 3 || a == 4);
        uApply = mUPend && (busy == 0) && !uWr;
        vApply = mVPend && (fe != 0) && !vWr;
        if (uApply) for (int i = 0; i < 3; i++) mApplied[i] = mShadow[i];
        if (vApply) for (int i = 3; i < 5; i++) mApplied[i] = mShadow[i];
        if ((v != 0) && (a <= 4)) mShadow[a] = d & mMask[a];
        mUPend = (mUPend && !uApply) || uWr;
        mVPend = (mVPend && !vApply) || vWr;
        eDrop = ((v != 0) && (a > 5)) ? 1 : 0;
        if ((mQ.size() > 0) && (ack != 0)) void'(mQ.pop_front());
        if ((v != 0) && (a == 5)) begin
            if (mQ.size() < DEPTH) mQ.push_back(d);
            else eDrop = 1;
        end
        eUu = uApply ? 1 : 0;
        eVu = vApply ? 1 : 0;
    endtask

    initial begin
        int expHeads[4];
        int eUu, eVu, eDrop, eRdy;

        // Directed vectors (v,a,d,busy,fe,ack | rdy,baud,par,stop,res,quad,uu,vu,drop)
        vecs.push_back('{1,0,4,1,0,0,        0,2,0,0,0,0,0,0,0});
        for (int i = 0; i < 9; i++)
            vecs.push_back('{0,0,0,1,0,0,    0,2,0,0,0,0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,        1,4,0,0,0,0,1,0,0});
        vecs.push_back('{0,0,0,0,0,0,        1,4,0,0,0,0,0,0,0});
        vecs.push_back('{1,3,1,0,1,0,        0,4,0,0,0,0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,        0,4,0,0,0,0,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,        1,4,0,0,1,0,0,1,0});
        vecs.push_back('{0,0,0,0,0,0,        1,4,0,0,1,0,0,0,0});
        vecs.push_back('{1,7,16383,0,0,0,    1,4,0,0,1,0,0,0,1});
        vecs.push_back('{0,0,0,0,0,0,        1,4,0,0,1,0,0,0,0});
        vecs.push_back('{1,1,16382,0,0,0,    0,4,0,0,1,0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,        1,4,2,0,1,0,1,0,0});
        vecs.push_back('{1,2,3,1,0,0,        0,4,2,0,1,0,0,0,0});
        vecs.push_back('{1,0,6,1,0,0,        0,4,2,0,1,0,0,0,0});
        vecs.push_back('{1,0,7,0,0,0,        0,4,2,0,1,0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,        1,7,2,1,1,0,1,0,0});
        vecs.push_back('{0,0,0,0,0,0,        1,7,2,1,1,0,0,0,0});
        vecs.push_back('{1,4,2,0,0,0,        0,7,2,1,1,0,0,0,0});
        vecs.push_back('{1,4,3,0,1,0,        0,7,2,1,1,0,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,        1,7,2,1,1,3,0,1,0});
        vecs.push_back('{1,6,0,0,0,0,        1,7,2,1,1,3,0,0,1});
        vecs.push_back('{0,0,0,0,0,0,        1,7,2,1,1,3,0,0,0});

        // Reset state, checked while reset is held.
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        checkOutput("rst.rdy",   bus.C_Rdy, 1);
        checkOutput("rst.baud",  Baud_Sel, 2);
        checkOutput("rst.par",   Parity_Sel, 0);
        checkOutput("rst.stop",  Stop_Sel, 0);
        checkOutput("rst.res",   Res_Sel, 0);
        checkOutput("rst.quad",  Quad_Sel, 0);
        checkOutput("rst.cv",    bus.Color_Valid, 0);
        checkOutput("rst.cdata", bus.Color_Data, 0);
        checkOutput("rst.uupd",  Uart_Cfg_Update, 0);
        checkOutput("rst.vupd",  Vga_Cfg_Update, 0);
        checkOutput("rst.drop",  bus.Cfg_Drop, 0);
        doReset();
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i], i);
        end

        // Colour FIFO fill, overflow drop, full push+pop, drain order.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5, i, 0, 0, 0);
            tick();
            checkOutput($sformatf("fill%0d.rdy", i), bus.C_Rdy, (i >= 3) ? 0 : 1);
            checkOutput($sformatf("fill%0d.cv", i), bus.Color_Valid, 1);
            checkOutput($sformatf("fill%0d.head", i), bus.Color_Data, 1);
        end
        drive(1, 5, 5, 0, 0, 0);
        tick();
        checkOutput("over.drop", bus.Cfg_Drop, 1);
        checkOutput("over.head", bus.Color_Data, 1);
        drive(1, 5, 'hAA, 0, 0, 1);
        tick();
        checkOutput("fullpp.drop", bus.Cfg_Drop, 0);
        checkOutput("fullpp.rdy", bus.C_Rdy, 0);
        expHeads = '{2, 3, 4, 'hAA};
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain%0d.cv", i), bus.Color_Valid, 1);
            checkOutput($sformatf("drain%0d.head", i), bus.Color_Data, expHeads[i]);
            drive(0, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checkOutput("drain.cv", bus.Color_Valid, 0);
        checkOutput("drain.rdy", bus.C_Rdy, 1);

        // Reset while a UART apply is pending.
        drive(1, 0, 5, 1, 0, 0);
        tick();
        checkOutput("rstpend.rdy0", bus.C_Rdy, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstpend.baud", Baud_Sel, 2);
        checkOutput("rstpend.stop", Stop_Sel, 0);
        checkOutput("rstpend.quad", Quad_Sel, 0);
        checkOutput("rstpend.rdy", bus.C_Rdy, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rstpend%0d.uupd", i), Uart_Cfg_Update, 0);
            checkOutput($sformatf("rstpend%0d.baud", i), Baud_Sel, 2);
        end

        // Randomized traffic against the reference model.
        doReset();
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int v, a, d, busy, fe, ack;
            v    = $urandom_range(0, 1);
            a    = $urandom_range(0, 7);
            d    = $urandom_range(0, 16383);
            busy = ($urandom_range(0, 1) == 0) ? 1 : 0;
            fe   = ($urandom_range(0, 5) == 0) ? 1 : 0;
            ack  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            modelStep(v, a, d, busy, fe, ack, eUu, eVu, eDrop);
            eRdy = (mUPend || mVPend || (mQ.size() >= DEPTH - 1)) ? 0 : 1;
            drive(v, a, d, busy, fe, ack);
            tick();
            checkOutput("rnd.rdy",  bus.C_Rdy, eRdy);
            checkOutput("rnd.baud", Baud_Sel, mApplied[0]);
            checkOutput("rnd.par",  Parity_Sel, mApplied[1]);
            checkOutput("rnd.stop", Stop_Sel, mApplied[2]);
            checkOutput("rnd.res",  Res_Sel, mApplied[3]);
            checkOutput("rnd.quad", Quad_Sel, mApplied[4]);
            checkOutput("rnd.uupd", Uart_Cfg_Update, eUu);
            checkOutput("rnd.vupd", Vga_Cfg_Update, eVu);
            checkOutput("rnd.drop", bus.Cfg_Drop, eDrop);
            checkOutput("rnd.cv",   bus.Color_Valid, (mQ.size() > 0) ? 1 : 0);
            if (mQ.size() > 0)
                checkOutput("rnd.head", bus.Color_Data, mQ[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
